uart_rx: RTL

//  UART receive path; the other end of the link from the UART transmitter in the same core.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, LSB-first, optional parity bit
//            (enabled by defining UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICKS   = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  i_ticks,
    output logic [DATA_WIDTH-1:0] o_data_byte,
    output logic                  o_rx_done,
    output logic                  o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  o_parity_err
`endif
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [2:0]            state;
    logic [4:0]            tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  armed;
`ifdef UART_RX_PARITY_EN
    logic                  perr;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        o_rx_done <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= 5'd0;
            bit_cnt     <= '0;
            shift       <= '0;
            armed       <= 1'b0;
            o_data_byte <= '0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr         <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state    <= START;
                        tick_cnt <= 5'd0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (i_ticks) begin
                        if (tick_cnt == 5'd7) begin
                            // Line back high at mid start bit: glitch, ignore it
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= 5'd0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_ticks) begin
                        if (tick_cnt == 5'd15) begin
                            shift    <= {rx_s, shift[DATA_WIDTH-1:1]};
                            tick_cnt <= 5'd0;
                            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_ticks) begin
                        if (tick_cnt == 5'd15) begin
                            perr     <= (^{shift, rx_s}) ^ PARITY_ODD;
                            tick_cnt <= 5'd0;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_ticks) begin
                        if (tick_cnt == 5'(SB_TICKS - 1)) begin
                            state       <= IDLE;
                            tick_cnt    <= 5'd0;
                            o_rx_done   <= 1'b1;
                            o_data_byte <= shift;
                            o_frame_err <= ~rx_s;
                            // A low stop bit disarms until the line returns high
                            armed       <= rx_s;
`ifdef UART_RX_PARITY_EN
                            o_parity_err <= perr;
`endif
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
